// File: rtl/seg_scan_decoder.sv
// Recovers the number shown on a scanned, active-low 7-segment display (loopback/self-test).
// Latency: 2 clk input sync, STABLE_CYCLES debounce, value_valid DIGITS+2 clk after completing sample.
// Backpressure: none; monitor only, results held until the next complete frame.
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS-1:0]     anode_n,
  input  logic [6:0]            cathode_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  value_valid,
  output logic                  pattern_err
);

  localparam int VW = 4 * DIGITS;
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  logic [DIGITS-1:0] an_s1, an_s2, an_prev;
  logic [6:0]        ca_s1, ca_s2, ca_prev;
  logic [CW-1:0]     cnt;
  logic [DIGITS-1:0] seen;
  logic              frame_err;
  logic [VW-1:0]     digit_reg;
  logic [VW-1:0]     snap;
  logic              snap_err;
  logic [VW-1:0]     acc;
  logic [IW-1:0]     idx;

  logic              changed;
  logic              sample_evt;
  logic [DIGITS-1:0] an_act;
  logic              one_hot;
  logic              samp_write;
  logic              snap_take;
  logic [3:0]        dec_digit;
  logic              dec_err;

  // Map a segment pattern to its digit; anything outside 0..9 decodes as 0 with an error flag.
  function automatic logic [4:0] decode(input logic [6:0] c);
    logic [4:0] r;
    case (c)
      7'b1000000: r = {1'b0, 4'd0};
      7'b1111001: r = {1'b0, 4'd1};
      7'b0100100: r = {1'b0, 4'd2};
      7'b0110000: r = {1'b0, 4'd3};
      7'b0011001: r = {1'b0, 4'd4};
      7'b0010010: r = {1'b0, 4'd5};
      7'b0000010: r = {1'b0, 4'd6};
      7'b1111000: r = {1'b0, 4'd7};
      7'b0000000: r = {1'b0, 4'd8};
      7'b0010000: r = {1'b0, 4'd9};
      default:    r = {1'b1, 4'd0};
    endcase
    return r;
  endfunction

  // Sample-event qualification: fires once per stable window, only for a single lit anode.
  always_comb begin
    changed    = ({an_s2, ca_s2} != {an_prev, ca_prev});
    sample_evt = !changed && (cnt == CW'(STABLE_CYCLES - 2));
    an_act     = ~an_s2;
    one_hot    = (an_act != '0) && ((an_act & (an_act - DIGITS'(1))) == '0);
    samp_write = sample_evt && one_hot;
    {dec_err, dec_digit} = decode(ca_s2);
    snap_take  = (state == COLLECT) && (seen == '1);
  end

  // Two-flop synchroniser; resets to a blank display.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_s1 <= '1;
      an_s2 <= '1;
      ca_s1 <= '1;
      ca_s2 <= '1;
    end else begin
      an_s1 <= anode_n;
      an_s2 <= an_s1;
      ca_s1 <= cathode_n;
      ca_s2 <= ca_s1;
    end
  end

  // Stability counter: cleared on any line change, saturates so each window samples once.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_prev <= '1;
      ca_prev <= '1;
      cnt     <= '0;
    end else begin
      an_prev <= an_s2;
      ca_prev <= ca_s2;
      if (changed)
        cnt <= '0;
      else if (cnt != CW'(STABLE_CYCLES - 1))
        cnt <= cnt + CW'(1);
    end
  end

  // Per-anode digit capture; a snapshot clears seen/frame_err but a same-cycle sample still lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen      <= '0;
      frame_err <= 1'b0;
      digit_reg <= '0;
    end else begin
      seen      <= (snap_take ? '0 : seen) | (samp_write ? an_act : '0);
      frame_err <= (snap_take ? 1'b0 : frame_err) | (samp_write & dec_err);
      for (int k = 0; k < DIGITS; k++) begin
        if (samp_write && an_act[k])
          digit_reg[4*k +: 4] <= dec_digit;
      end
    end
  end

  // Frame FSM: snapshot, BCD-to-binary MSD first with shift-add *10, then publish outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      snap        <= '0;
      snap_err    <= 1'b0;
      acc         <= '0;
      idx         <= '0;
      value       <= '0;
      bcd         <= '0;
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      case (state)
        COLLECT: begin
          if (snap_take) begin
            snap     <= digit_reg;
            snap_err <= frame_err;
            acc      <= '0;
            idx      <= IW'(DIGITS - 1);
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          acc <= (acc << 3) + (acc << 1) + VW'(snap[4*idx +: 4]);
          if (idx == '0)
            state <= DONE;
          else
            idx <= idx - IW'(1);
        end
        DONE: begin
          value       <= acc;
          bcd         <= snap;
          pattern_err <= snap_err;
          value_valid <= 1'b1;
          state       <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode_n;
  logic [6:0]  cathode_n;
  logic [15:0] value;
  logic [15:0] bcd;
  logic        value_valid;
  logic        pattern_err;

  int n_tests = 0;
  int n_fail  = 0;
  int vv_cnt  = 0;

  seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .anode_n     (anode_n),
    .cathode_n   (cathode_n),
    .value       (value),
    .bcd         (bcd),
    .value_valid (value_valid),
    .pattern_err (pattern_err)
  );

  always #5 clk = ~clk;

  // Count every cycle value_valid is high, so a stretched pulse shows up as an extra count.
  always @(negedge clk) if (value_valid === 1'b1) vv_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic hold(input logic [3:0] an, input logic [6:0] ca, input int n);
    anode_n   = an;
    cathode_n = ca;
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    hold(4'b1111, 7'b1111111, n);
  endtask

  // One pass over the four anodes, digit k taken from nibble k; nibble F shows a blank digit.
  task automatic scan_frame(input logic [15:0] digs);
    logic [3:0] a;
    for (int k = 0; k < 4; k++) begin
      a = 4'b0001 << k;
      hold(~a, seg(digs[4*k +: 4]), 40);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    blank(3);
    reset = 1'b0;
    blank(2);
    n_tests++; if (value !== 16'h0)     begin n_fail++; $display("FAIL reset_value got %h exp 0000", value); end
    n_tests++; if (bcd !== 16'h0)       begin n_fail++; $display("FAIL reset_bcd got %h exp 0000", bcd); end
    n_tests++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vv got %b exp 0", value_valid); end
    n_tests++; if (pattern_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", pattern_err); end
  endtask

  task automatic test_basic_1234;
    int c0;
    c0 = vv_cnt;
    scan_frame(16'h1234);
    blank(30);
    n_tests++; if (value !== 16'd1234)   begin n_fail++; $display("FAIL basic_value got %0d exp 1234", value); end
    n_tests++; if (bcd !== 16'h1234)     begin n_fail++; $display("FAIL basic_bcd got %h exp 1234", bcd); end
    n_tests++; if (pattern_err !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b exp 0", pattern_err); end
    n_tests++; if (vv_cnt - c0 !== 1)    begin n_fail++; $display("FAIL basic_pulses got %0d exp 1", vv_cnt - c0); end
  endtask

  task automatic test_glitch;
    int c0;
    logic [3:0] a;
    logic [15:0] digs;
    digs = 16'h1234;
    // Glitch at slot start, shorter than the debounce window.
    c0 = vv_cnt;
    for (int k = 0; k < 4; k++) begin
      a = 4'b0001 << k;
      hold(~a, 7'b0110110, 5);
      hold(~a, seg(digs[4*k +: 4]), 35);
    end
    blank(30);
    n_tests++; if (value !== 16'd1234) begin n_fail++; $display("FAIL glitch_start_value got %0d exp 1234", value); end
    n_tests++; if (pattern_err !== 1'b0) begin n_fail++; $display("FAIL glitch_start_err got %b exp 0", pattern_err); end
    n_tests++; if (vv_cnt - c0 !== 1)  begin n_fail++; $display("FAIL glitch_start_pulses got %0d exp 1", vv_cnt - c0); end
    // Mid-slot glitch followed by too short a stable tail to resample.
    c0 = vv_cnt;
    for (int k = 0; k < 4; k++) begin
      a = 4'b0001 << k;
      hold(~a, seg(digs[4*k +: 4]), 20);
      hold(~a, 7'b0110110, 10);
      hold(~a, seg(digs[4*k +: 4]), 10);
    end
    blank(30);
    n_tests++; if (value !== 16'd1234) begin n_fail++; $display("FAIL glitch_mid_value got %0d exp 1234", value); end
    n_tests++; if (pattern_err !== 1'b0) begin n_fail++; $display("FAIL glitch_mid_err got %b exp 0", pattern_err); end
    n_tests++; if (vv_cnt - c0 !== 1)  begin n_fail++; $display("FAIL glitch_mid_pulses got %0d exp 1", vv_cnt - c0); end
  endtask

  task automatic test_pattern_err;
    int c0;
    c0 = vv_cnt;
    scan_frame(16'h90F5);
    blank(30);
    n_tests++; if (value !== 16'd9005)   begin n_fail++; $display("FAIL perr_value got %0d exp 9005", value); end
    n_tests++; if (bcd !== 16'h9005)     begin n_fail++; $display("FAIL perr_bcd got %h exp 9005", bcd); end
    n_tests++; if (pattern_err !== 1'b1) begin n_fail++; $display("FAIL perr_err got %b exp 1", pattern_err); end
    n_tests++; if (vv_cnt - c0 !== 1)    begin n_fail++; $display("FAIL perr_pulses got %0d exp 1", vv_cnt - c0); end
    scan_frame(16'h4321);
    blank(30);
    n_tests++; if (value !== 16'd4321)   begin n_fail++; $display("FAIL perr_clear_value got %0d exp 4321", value); end
    n_tests++; if (pattern_err !== 1'b0) begin n_fail++; $display("FAIL perr_clear_err got %b exp 0", pattern_err); end
  endtask

  task automatic test_bad_anodes;
    int c0;
    c0 = vv_cnt;
    hold(4'b1100, seg(4'd7), 100);
    hold(4'b1111, seg(4'd7), 100);
    blank(10);
    n_tests++; if (dut.seen !== 4'b0000) begin n_fail++; $display("FAIL badan_seen got %b exp 0000", dut.seen); end
    n_tests++; if (vv_cnt - c0 !== 0)    begin n_fail++; $display("FAIL badan_pulses got %0d exp 0", vv_cnt - c0); end
    n_tests++; if (value !== 16'd4321)   begin n_fail++; $display("FAIL badan_value got %0d exp 4321", value); end
  endtask

  task automatic test_reset_mid_convert;
    int c0;
    bit found;
    c0 = vv_cnt;
    found = 1'b0;
    hold(4'b1110, seg(4'd8), 40);
    hold(4'b1101, seg(4'd7), 40);
    hold(4'b1011, seg(4'd6), 40);
    anode_n   = 4'b0111;
    cathode_n = seg(4'd5);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (dut.state == 2'd1) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rst_mid_reach got no_convert exp convert_within_40"); end
    @(negedge clk);
    reset = 1'b1;
    blank(2);
    reset = 1'b0;
    blank(30);
    n_tests++; if (value !== 16'h0)      begin n_fail++; $display("FAIL rst_mid_value got %0d exp 0", value); end
    n_tests++; if (bcd !== 16'h0)        begin n_fail++; $display("FAIL rst_mid_bcd got %h exp 0000", bcd); end
    n_tests++; if (vv_cnt - c0 !== 0)    begin n_fail++; $display("FAIL rst_mid_pulses got %0d exp 0", vv_cnt - c0); end
    scan_frame(16'h0999);
    blank(30);
    n_tests++; if (value !== 16'd999)    begin n_fail++; $display("FAIL rst_next_value got %0d exp 999", value); end
    n_tests++; if (bcd !== 16'h0999)     begin n_fail++; $display("FAIL rst_next_bcd got %h exp 0999", bcd); end
    n_tests++; if (vv_cnt - c0 !== 1)    begin n_fail++; $display("FAIL rst_next_pulses got %0d exp 1", vv_cnt - c0); end
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = vv_cnt;
    for (int f = 0; f < 3; f++) scan_frame(16'h8888);
    blank(30);
    n_tests++; if (value !== 16'd8888)   begin n_fail++; $display("FAIL b2b_value got %0d exp 8888", value); end
    n_tests++; if (bcd !== 16'h8888)     begin n_fail++; $display("FAIL b2b_bcd got %h exp 8888", bcd); end
    n_tests++; if (vv_cnt - c0 !== 3)    begin n_fail++; $display("FAIL b2b_pulses got %0d exp 3", vv_cnt - c0); end
  endtask

  initial begin
    reset     = 1'b1;
    anode_n   = 4'b1111;
    cathode_n = 7'b1111111;
    @(negedge clk);
    test_reset();
    test_basic_1234();
    test_glitch();
    test_pattern_err();
    test_bad_anodes();
    test_reset_mid_convert();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
